axi_lite_reg_bridge: RTL and testbench



---
 rtl/axi_lite_pkg.sv | 33 +++
 rtl/axi_lite_rd_path.sv | 89 ++++++++
 rtl/axi_lite_reg_bridge.sv | 140 ++++++++++++++
 tb/tb_axi_lite_reg_bridge.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register bridge.
// Holds the response encoding, both FSM state enums and the readable word index.
// No logic; imported by axi_lite_reg_bridge and axi_lite_rd_path.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ISSUE,
    W_WAIT,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ISSUE,
    R_WAIT,
    R_RESP
  } rd_state_t;

  // The only downstream word index that returns meaningful read data.
  localparam int unsigned RD_INDEX = 1;

  // Map the downstream slave's registered acknowledge onto an AXI response.
  function automatic axi_resp_t ack_to_resp(input logic ack);
    return ack ? OKAY : SLVERR;
  endfunction

endpackage

// File: rtl/axi_lite_rd_path.sv
// Read path: AR handshake -> one-cycle readAddress strobe -> capture readData -> R beat.
// Latency: AR accepted in N, strobe N+1, readData sampled N+2, rvalid from N+3.
// Backpressure: arready only in R_IDLE; rvalid/rdata/rresp held stable until rready.
// Optional AXI_BRIDGE_SLVERR_EN: reads of any index other than RD_INDEX return SLVERR.
module axi_lite_rd_path
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  localparam int AXI_ADDR_WIDTH = ADDR_WIDTH + 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [ADDR_WIDTH-1:0]     readAddress,
  input  logic [DATA_WIDTH-1:0]     readData
);

  localparam logic [ADDR_WIDTH-1:0] LP_RD_IDX = ADDR_WIDTH'(RD_INDEX);

  rd_state_t               r_state;
  rd_state_t               w_state_nxt;
  logic                    r_arready;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [DATA_WIDTH-1:0]   r_rdata;
  axi_resp_t               r_rresp;
  axi_resp_t               w_rresp_nxt;
  logic                    w_ar_hs;
  logic                    w_unused_ar;

  assign w_ar_hs     = arvalid & r_arready;
  // Byte-lane bits are not decoded.
  assign w_unused_ar = ^araddr[1:0];

  // State register plus the registered AR ready, latched index and R payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      r_arready <= 1'b0;
      r_idx     <= '0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      r_state   <= w_state_nxt;
      r_arready <= (w_state_nxt == R_IDLE);
      if (w_ar_hs) begin
        r_idx <= araddr[ADDR_WIDTH+1:2];
      end
      if (r_state == R_WAIT) begin
        r_rdata <= readData;
        r_rresp <= w_rresp_nxt;
      end
    end
  end

  // Next-state: one cycle each in ISSUE and WAIT, then hold RESP until rready.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (w_ar_hs) w_state_nxt = R_ISSUE;
      R_ISSUE: w_state_nxt = R_WAIT;
      R_WAIT:  w_state_nxt = R_RESP;
      R_RESP:  if (rready) w_state_nxt = R_IDLE;
      default: w_state_nxt = R_IDLE;
    endcase
  end

  // Outputs: the downstream address rests at the no-op index 0 outside ISSUE.
  always_comb begin
    readAddress = (r_state == R_ISSUE) ? r_idx : '0;
    rvalid      = (r_state == R_RESP);
`ifdef AXI_BRIDGE_SLVERR_EN
    w_rresp_nxt = (r_idx == LP_RD_IDX) ? OKAY : SLVERR;
`else
    w_rresp_nxt = OKAY;
`endif
  end

  assign arready = r_arready;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

endmodule

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave to single-cycle register strobe bridge; write FSM here, read FSM in axi_lite_rd_path.
// Latency: last of AW/W (or AR) accepted in N, strobe N+1, ack sampled N+2, bvalid/rvalid from N+3.
// Backpressure: one transaction per direction; readies low while busy, B/R held stable until ready.
// Optional AXI_BRIDGE_SLVERR_EN: writeResponse = 0 gives SLVERR; otherwise all responses are OKAY.
module axi_lite_reg_bridge
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  localparam int AXI_ADDR_WIDTH = ADDR_WIDTH + 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [AXI_ADDR_WIDTH-1:0] araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [ADDR_WIDTH-1:0]     writeAddress,
  output logic [DATA_WIDTH-1:0]     writeData,
  input  logic                      writeResponse,
  output logic [ADDR_WIDTH-1:0]     readAddress,
  input  logic [DATA_WIDTH-1:0]     readData
);

  wr_state_t               r_wstate;
  wr_state_t               w_wstate_nxt;
  logic                    r_aw_held;
  logic                    r_w_held;
  logic                    r_awready;
  logic                    r_wready;
  logic [ADDR_WIDTH-1:0]   r_awidx;
  logic [DATA_WIDTH-1:0]   r_wdata;
  axi_resp_t               r_bresp;
  axi_resp_t               w_bresp_nxt;
  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_aw_held_nxt;
  logic                    w_w_held_nxt;
  logic                    w_unused_aw;

  assign w_aw_hs       = awvalid & r_awready;
  assign w_w_hs        = wvalid & r_wready;
  // Readies are only high in W_IDLE, so these only accumulate while idle.
  assign w_aw_held_nxt = r_aw_held | w_aw_hs;
  assign w_w_held_nxt  = r_w_held | w_w_hs;
  // Byte-lane bits are not decoded.
  assign w_unused_aw   = ^awaddr[1:0];

`ifndef AXI_BRIDGE_SLVERR_EN
  logic w_unused_wresp;
  assign w_unused_wresp = writeResponse;
`endif

  // State register, beat-held flags, registered readies and latched AW/W/B payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_awidx   <= '0;
      r_wdata   <= '0;
      r_bresp   <= OKAY;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_aw_held <= (w_wstate_nxt == W_IDLE) & w_aw_held_nxt;
      r_w_held  <= (w_wstate_nxt == W_IDLE) & w_w_held_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE) & ~w_aw_held_nxt;
      r_wready  <= (w_wstate_nxt == W_IDLE) & ~w_w_held_nxt;
      if (w_aw_hs) begin
        r_awidx <= awaddr[ADDR_WIDTH+1:2];
      end
      if (w_w_hs) begin
        r_wdata <= wdata;
      end
      if (r_wstate == W_WAIT) begin
        r_bresp <= w_bresp_nxt;
      end
    end
  end

  // Next-state: leave IDLE once both beats are held, in either order or together.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_held_nxt & w_w_held_nxt) w_wstate_nxt = W_ISSUE;
      W_ISSUE: w_wstate_nxt = W_WAIT;
      W_WAIT:  w_wstate_nxt = W_RESP;
      W_RESP:  if (bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Outputs: strobe only in ISSUE, otherwise rest at the no-op index with zero data.
  always_comb begin
    writeAddress = (r_wstate == W_ISSUE) ? r_awidx : '0;
    writeData    = (r_wstate == W_ISSUE) ? r_wdata : '0;
    bvalid       = (r_wstate == W_RESP);
`ifdef AXI_BRIDGE_SLVERR_EN
    w_bresp_nxt  = ack_to_resp(writeResponse);
`else
    w_bresp_nxt  = OKAY;
`endif
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bresp   = r_bresp;

  axi_lite_rd_path #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_path (
    .clk         (clk),
    .rst         (rst),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .readAddress (readAddress),
    .readData    (readData)
  );

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Directed bench for axi_lite_reg_bridge with a registered downstream slave model.
// Expected strobes and responses are queued when stimulus is driven and popped on DUT output.
// Build with or without AXI_BRIDGE_SLVERR_EN; expected responses follow the same macro.
`define CHK(tag, o, e) check(tag, 64'(o), 64'(e))

module tb_axi_lite_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [1:0]  writeAddress;
  logic [31:0] writeData;
  logic        writeResponse;
  logic [1:0]  readAddress;
  logic [31:0] readData;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] data;
  } strobe_t;

  strobe_t     exp_ws_q[$];
  logic [1:0]  exp_b_q[$];
  logic [1:0]  exp_rs_q[$];
  logic [33:0] exp_r_q[$];

  always #5 clk = ~clk;

  axi_lite_reg_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .awaddr        (awaddr),
    .awvalid       (awvalid),
    .awready       (awready),
    .wdata         (wdata),
    .wvalid        (wvalid),
    .wready        (wready),
    .bresp         (bresp),
    .bvalid        (bvalid),
    .bready        (bready),
    .araddr        (araddr),
    .arvalid       (arvalid),
    .arready       (arready),
    .rdata         (rdata),
    .rresp         (rresp),
    .rvalid        (rvalid),
    .rready        (rready),
    .writeAddress  (writeAddress),
    .writeData     (writeData),
    .writeResponse (writeResponse),
    .readAddress   (readAddress),
    .readData      (readData)
  );

  // Downstream register slave: registered ack (NACK on the no-op index) and read data.
  always @(posedge clk) begin
    writeResponse <= (writeAddress != 2'd0);
    readData      <= (readAddress == 2'd1) ? 32'hCAFEF00D : 32'h0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit 200000 reached before finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [1:0] exp_bresp(input logic [1:0] idx);
`ifdef AXI_BRIDGE_SLVERR_EN
    return (idx != 2'd0) ? 2'b00 : 2'b10;
`else
    return 2'b00;
`endif
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [1:0] idx);
`ifdef AXI_BRIDGE_SLVERR_EN
    return (idx == 2'd1) ? 2'b00 : 2'b10;
`else
    return 2'b00;
`endif
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [1:0] idx);
    return (idx == 2'd1) ? 32'hCAFEF00D : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_empty(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s: observed empty scoreboard expected a pending entry", tag);
  endtask

  task automatic push_write(input logic [3:0] addr, input logic [31:0] data);
    logic [1:0] idx;
    idx = addr[3:2];
    exp_ws_q.push_back({idx, data});
    exp_b_q.push_back(exp_bresp(idx));
  endtask

  task automatic push_read(input logic [3:0] addr);
    logic [1:0] idx;
    idx = addr[3:2];
    exp_rs_q.push_back(idx);
    exp_r_q.push_back({exp_rresp(idx), exp_rdata(idx)});
  endtask

  task automatic chk_wstrobe();
    strobe_t s;
    if (exp_ws_q.size() == 0) sb_empty("w_strobe");
    else begin
      s = exp_ws_q.pop_front();
      `CHK("w_strobe_addr", writeAddress, s.idx);
      `CHK("w_strobe_data", writeData, s.data);
    end
  endtask

  task automatic chk_rstrobe();
    logic [1:0] idx;
    if (exp_rs_q.size() == 0) sb_empty("r_strobe");
    else begin
      idx = exp_rs_q.pop_front();
      `CHK("r_strobe_addr", readAddress, idx);
    end
  endtask

  task automatic chk_b(input string tag);
    logic [1:0] b;
    `CHK({tag, "_bvalid"}, bvalid, 1'b1);
    if (exp_b_q.size() == 0) sb_empty("b_resp");
    else begin
      b = exp_b_q.pop_front();
      `CHK({tag, "_bresp"}, bresp, b);
    end
  endtask

  task automatic chk_r(input string tag, output logic [33:0] r);
    r = '0;
    `CHK({tag, "_rvalid"}, rvalid, 1'b1);
    if (exp_r_q.size() == 0) sb_empty("r_beat");
    else begin
      r = exp_r_q.pop_front();
      `CHK({tag, "_rdata"}, rdata, r[31:0]);
      `CHK({tag, "_rresp"}, rresp, r[33:32]);
    end
  endtask

  // Called in cycle N+1 after the last write beat was accepted in cycle N.
  task automatic write_tail(input int hold);
    logic [1:0] b_seen;
    chk_wstrobe();
    tick();
    `CHK("w_strobe_one_cycle", {writeAddress, writeData}, 34'd0);
    `CHK("w_bvalid_early", bvalid, 1'b0);
    bready = (hold == 0);
    tick();
    chk_b("w_n3");
    b_seen = bresp;
    for (int i = 0; i < hold; i++) begin
      tick();
      `CHK("w_bvalid_hold", bvalid, 1'b1);
      `CHK("w_bresp_stable", bresp, b_seen);
      `CHK("w_awready_busy", awready, 1'b0);
    end
    bready = 1'b1;
    tick();
    `CHK("w_bvalid_done", bvalid, 1'b0);
    `CHK("w_readies_back", {awready, wready}, 2'b11);
  endtask

  // Called in cycle N+1 after AR was accepted in cycle N.
  task automatic read_tail(input int hold);
    logic [33:0] r;
    chk_rstrobe();
    tick();
    `CHK("r_strobe_one_cycle", readAddress, 2'd0);
    `CHK("r_rvalid_early", rvalid, 1'b0);
    rready = (hold == 0);
    tick();
    chk_r("r_n3", r);
    for (int i = 0; i < hold; i++) begin
      tick();
      `CHK("r_rvalid_hold", rvalid, 1'b1);
      `CHK("r_rdata_stable", rdata, r[31:0]);
      `CHK("r_arready_busy", arready, 1'b0);
    end
    rready = 1'b1;
    tick();
    `CHK("r_rvalid_done", rvalid, 1'b0);
    `CHK("r_arready_back", arready, 1'b1);
    rready = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    `CHK({tag, "_readies"}, {awready, wready, arready}, 3'b000);
    `CHK({tag, "_valids"}, {bvalid, rvalid}, 2'b00);
    `CHK({tag, "_resps"}, {bresp, rresp}, 4'b0000);
    `CHK({tag, "_rdata"}, rdata, 32'h0);
    `CHK({tag, "_downstream"}, {writeAddress, writeData, readAddress}, 36'd0);
  endtask

  initial begin
    logic [33:0] r;
    bit          saw_valid;
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;

    repeat (3) tick();
    chk_reset_values("reset");
    rst = 1'b0;
    tick();
    `CHK("readies_after_reset", {awready, wready, arready}, 3'b111);

    // AW and W in the same cycle.
    awaddr = 4'h8; wdata = 32'hDEADBEEF; awvalid = 1'b1; wvalid = 1'b1;
    push_write(awaddr, wdata);
    `CHK("t1_readies", {awready, wready}, 2'b11);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    `CHK("t1_busy", {awready, wready}, 2'b00);
    write_tail(0);

    // W five cycles ahead of AW, with B backpressure.
    wdata = 32'h00001234; wvalid = 1'b1;
    push_write(4'hC, wdata);
    `CHK("t2_wready", wready, 1'b1);
    tick();
    wvalid = 1'b0;
    `CHK("t2_wready_drop", wready, 1'b0);
    `CHK("t2_awready_open", awready, 1'b1);
    repeat (4) tick();
    `CHK("t2_no_strobe", writeAddress, 2'd0);
    `CHK("t2_wready_low", wready, 1'b0);
    awaddr = 4'hC; awvalid = 1'b1;
    `CHK("t2_awready", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    write_tail(2);

    // Read with rready held low for 4 cycles.
    araddr = 4'h4; arvalid = 1'b1;
    push_read(araddr);
    `CHK("t3_arready", arready, 1'b1);
    tick();
    arvalid = 1'b0;
    `CHK("t3_arready_busy", arready, 1'b0);
    read_tail(4);

    // Write to the no-op index and read from an unreadable index.
    awaddr = 4'h0; wdata = 32'h00000055; awvalid = 1'b1; wvalid = 1'b1;
    push_write(awaddr, wdata);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    write_tail(0);
    araddr = 4'h8; arvalid = 1'b1;
    push_read(araddr);
    tick();
    arvalid = 1'b0;
    read_tail(0);

    // Concurrent read and write.
    awaddr = 4'hC; wdata = 32'hA5A50001; araddr = 4'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; rready = 1'b1; bready = 1'b1;
    push_write(awaddr, wdata);
    push_read(araddr);
    `CHK("t5_readies", {awready, wready, arready}, 3'b111);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk_wstrobe();
    chk_rstrobe();
    tick();
    `CHK("t5_valids_early", {bvalid, rvalid}, 2'b00);
    tick();
    chk_b("t5");
    chk_r("t5", r);
    tick();
    `CHK("t5_valids_done", {bvalid, rvalid}, 2'b00);
    rready = 1'b0;

    // Reset during W_WAIT and R_ISSUE.
    awaddr = 4'h4; wdata = 32'h00000077; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    `CHK("t6_w_issue", writeAddress, 2'd1);
    araddr = 4'h4; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    `CHK("t6_r_issue", readAddress, 2'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_values("t6_abort");
    tick();
    `CHK("t6_readies_back", {awready, wready, arready}, 3'b111);
    rready = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      saw_valid = saw_valid | bvalid | rvalid;
    end
    `CHK("t6_no_response", saw_valid, 1'b0);

    `CHK("sb_drained", exp_ws_q.size() + exp_b_q.size() + exp_rs_q.size() + exp_r_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
